bldc_sensorless_commutator: RTL
===============================

Name: bldc_sensorless_commutator

Overview:
- Parametrised successor of the closed-loop six-step commutation FSM in flight_control.
- Adds zero-crossing (ZC) glitch filtering, post-commutation blanking, and a timed 30° commutation delay.
- Adds an open-loop alignment/ramp startup with automatic lock into closed loop, direction select, and stall detection.
- Drives the H-bridge gate-status word consumed by the PWM gating stage.

Parameters:
- FILT_LEN, 3: consecutive identical raw samples needed to change a filtered ZC level (1..15).
- CNT_W, 16: width of all timers, period and interval registers.
- BLANK_CYC, 64: cycles after each commutation during which ZC edges are ignored.
- ALIGN_CYC, 50000: cycles held in the alignment vector.
- START_PERIOD, 40000: first open-loop commutation period in cycles.
- MIN_PERIOD, 8000: floor of the open-loop period.
- RAMP_STEP, 500: period decrement applied per open-loop commutation.
- LOCK_CNT, 6: consecutive valid ZC events needed to enter closed loop.
- OL_MAX_STEPS, 120: open-loop commutations allowed before FAULT.
- STALL_CYC, 60000: closed-loop cycles since the last commutation with no accepted ZC before FAULT.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active high
- ena_i  in  1  run enable; low forces IDLE
- dir_i  in  1  direction; 0 = forward, 1 = reverse; sampled only when leaving IDLE
- zero_crossing_i  in  3  raw comparators, A[2] B[1] C[0]
- status_o  out  6  {AHS,ALS,BHS,BLS,CHS,CLS}
- state_o  out  3  0 IDLE, 1 ALIGN, 2 OPEN, 3 CLOSED, 4 FAULT
- locked_o  out  1  high while in CLOSED
- fault_o  out  1  high while in FAULT
- interval_o  out  CNT_W  last measured ZC-to-ZC interval in cycles

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state IDLE; status_o, interval_o, step, timers and lock counter all 0.
  - Filtered ZC levels set to 0; locked_o and fault_o 0.
- Step table:
  - s0 100100, s1 100001, s2 001001, s3 011000, s4 010010, s5 000110.
  - Forward: step+1 mod 6. Reverse: step-1 mod 6 (s0 wraps to s5).
- Expected ZC edge per step, forward: s0 fall C, s1 rise B, s2 fall A, s3 rise C, s4 fall B, s5 rise A.
- Expected ZC edge per step, reverse: same phase as forward, opposite polarity.
- status_o is registered: it reflects the step/state of the previous cycle, giving 1-cycle latency. It is 0 in IDLE and FAULT.
- Filter:
  - Per phase, a saturating run counter.
  - The filtered level takes the raw value once raw has differed from filtered for FILT_LEN consecutive cycles.
  - Edges are detected on the filtered level; one pulse per edge.
- Blanking:
  - A counter loads BLANK_CYC on every commutation.
  - Edges seen while it is nonzero are discarded.
  - Only the expected edge of the current step is "valid"; any other edge is ignored.
- IDLE:
  - When ena_i=1, latch dir_i, set step s0, and go to ALIGN.
- ALIGN:
  - Output s0 for ALIGN_CYC cycles.
  - Then go to OPEN with period=START_PERIOD and commute.
- OPEN:
  - Commute each time the period timer expires; after each commutation, period = max(period-RAMP_STEP, MIN_PERIOD).
  - Each commutation with a valid ZC seen since the previous one increments the lock counter; a commutation without one clears it.
  - When the lock counter reaches LOCK_CNT, go to CLOSED on that commutation.
  - If OL_MAX_STEPS commutations occur without lock, go to FAULT.
- CLOSED:
  - A free-running interval counter saturates at 2^CNT_W-1.
  - On a valid ZC: interval_o ← counter, counter ← 0, delay ← counter>>1. Commute exactly delay cycles later; delay=0 commutes on the next cycle.
  - The first closed-loop ZC uses the last open-loop period>>1 as the delay.
  - A second valid ZC while a delay is pending is impossible, because the step only changes on commutation.
  - If no valid ZC arrives within STALL_CYC cycles after a commutation, go to FAULT.
- FAULT:
  - Outputs 0, fault_o=1.
  - Exits only via ena_i=0 (to IDLE) or reset.
- ena_i=0 in any state: next state IDLE, status_o=0 the following cycle, lock counter and timers cleared.
- Simultaneous events:
  - rst_i overrides ena_i.
  - ena_i=0 overrides timer expiry and ZC.
  - In OPEN, a valid ZC in the same cycle as timer expiry counts for the commutation being made.

Test Plan:
- Reset → status_o=000000, state_o=0 for 3 cycles; ena_i=1, dir_i=0 → state_o=1, status_o=100100 one cycle later, held for ALIGN_CYC.
- Open-loop ramp with ZC tied 0 → commutation gaps 40000, 39500, 39000 ... floor at 8000; FAULT after 120 commutations, status_o=0.
- Model back-EMF producing the correct forward edges at mid-step → locked_o=1 after 6th valid ZC. With a ZC interval of 10000, the next commutation occurs 5000 cycles after the ZC, and interval_o=10000.
- Glitches: 2-cycle pulses with FILT_LEN=3 are ignored; an expected edge inside BLANK_CYC is ignored; a wrong-polarity edge is ignored; step sequence is unchanged.
- dir_i=1 with a matching reverse-EMF model → steps s0,s5,s4,s3,... and lock.
- In CLOSED, stop ZC → FAULT exactly STALL_CYC cycles after the last commutation. Drop ena_i mid-delay → IDLE, status_o=0 next cycle, no further commutation.

Source files
------------

// File: rtl/bldc_sensorless_commutator.sv
// Sensorless six-step BLDC commutator: ZC filter/blanking, align + open-loop ramp, closed-loop 30 deg delay, stall fault.
// Latency: status_o is registered one cycle behind the internal step/state; ZC edges act on the cycle the filter flips.
// Backpressure: none; free-running controller, ena_i=0 forces IDLE and blanks the gate word on the next cycle.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   ena_i, dir_i           run enable, direction (0 fwd / 1 rev, latched leaving IDLE)
//   zero_crossing_i[2:0]   raw back-EMF comparators A[2] B[1] C[0]
//   status_o[5:0]          gate word {AHS,ALS,BHS,BLS,CHS,CLS}
//   state_o[2:0]           0 IDLE, 1 ALIGN, 2 OPEN, 3 CLOSED, 4 FAULT
//   locked_o, fault_o      in CLOSED / in FAULT
//   interval_o[CNT_W-1:0]  last ZC-to-ZC interval in cycles
module bldc_sensorless_commutator #(
  parameter int FILT_LEN     = 3,
  parameter int CNT_W        = 16,
  parameter int BLANK_CYC    = 64,
  parameter int ALIGN_CYC    = 50000,
  parameter int START_PERIOD = 40000,
  parameter int MIN_PERIOD   = 8000,
  parameter int RAMP_STEP    = 500,
  parameter int LOCK_CNT     = 6,
  parameter int OL_MAX_STEPS = 120,
  parameter int STALL_CYC    = 60000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic             dir_i,
  input  logic [2:0]       zero_crossing_i,
  output logic [5:0]       status_o,
  output logic [2:0]       state_o,
  output logic             locked_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] interval_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_OPEN   = 3'd2,
    ST_CLOSED = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam int W1 = CNT_W + 1;
  localparam logic [CNT_W-1:0] ONE        = 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_CYC - 1);
  localparam logic [CNT_W-1:0] START_P    = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] RAMP       = CNT_W'(RAMP_STEP);
  localparam logic [W1-1:0]    RAMP_FLOOR = W1'(MIN_PERIOD + RAMP_STEP);
  localparam logic [CNT_W-1:0] LOCK_N     = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] OL_MAX     = CNT_W'(OL_MAX_STEPS);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_N    = CNT_W'(BLANK_CYC);
  localparam logic [4:0]       FILT_N     = 5'(FILT_LEN);

  // Gate word per step.
  function automatic logic [5:0] step_pattern(input logic [2:0] s);
    case (s)
      3'd0:    step_pattern = 6'b100100;
      3'd1:    step_pattern = 6'b100001;
      3'd2:    step_pattern = 6'b001001;
      3'd3:    step_pattern = 6'b011000;
      3'd4:    step_pattern = 6'b010010;
      3'd5:    step_pattern = 6'b000110;
      default: step_pattern = 6'b000000;
    endcase
  endfunction

  function automatic logic [2:0] step_next(input logic [2:0] s, input logic rev);
    if (rev) step_next = (s == 3'd0) ? 3'd5 : s - 3'd1;
    else     step_next = (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  // Floating phase watched in each step: C for s0/s3, B for s1/s4, A for s2/s5.
  function automatic logic [1:0] phase_of(input logic [2:0] s);
    case (s)
      3'd0, 3'd3: phase_of = 2'd0;
      3'd1, 3'd4: phase_of = 2'd1;
      default:    phase_of = 2'd2;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic             dir_q, dir_d;
  logic [5:0]       status_q, status_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] ivl_cnt_q, ivl_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] blank_q, blank_d;
  logic [CNT_W-1:0] lock_q, lock_d;
  logic [CNT_W-1:0] ol_cnt_q, ol_cnt_d;
  logic             zc_seen_q, zc_seen_d;
  logic             pend_q, pend_d;
  logic             first_q, first_d;
  logic [2:0]       filt_q, filt_d;
  logic [2:0][3:0]  run_q, run_d;

  logic [2:0]       zc_rise, zc_fall;
  logic [1:0]       exp_phase;
  logic             exp_rise;
  logic             zc_valid;
  logic             commute;
  logic             zc_seen_now;
  logic [CNT_W-1:0] lock_nxt, ol_nxt, new_period, ivl_inc;
  logic [4:0]       run_ext;

  // Glitch filter: the run counter clears whenever raw agrees with the filtered
  // level, so it never exceeds FILT_LEN-1 and cannot wrap.
  always_comb begin
    filt_d  = filt_q;
    run_d   = '0;
    run_ext = '0;
    for (int p = 0; p < 3; p++) begin
      if (zero_crossing_i[p] != filt_q[p]) begin
        run_ext = {1'b0, run_q[p]} + 5'd1;
        if (run_ext >= FILT_N) begin
          filt_d[p] = zero_crossing_i[p];
        end else begin
          run_d[p] = run_ext[3:0];
        end
      end
    end
  end

  // Edge pulses come straight from the flip so the event is acted on this cycle.
  assign zc_rise   = filt_d & ~filt_q;
  assign zc_fall   = ~filt_d & filt_q;
  assign exp_phase = phase_of(step_q);
  // Forward expects a rise on odd steps; reverse flips the polarity.
  assign exp_rise  = step_q[0] ^ dir_q;
  assign zc_valid  = (blank_q == '0) &&
                     (exp_rise ? zc_rise[exp_phase] : zc_fall[exp_phase]);

  // Interval counter saturates instead of wrapping on a very slow rotor.
  assign ivl_inc = (ivl_cnt_q == CNT_MAX) ? CNT_MAX : ivl_cnt_q + ONE;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    dir_d       = dir_q;
    interval_d  = interval_q;
    timer_d     = timer_q;
    period_d    = period_q;
    ivl_cnt_d   = ivl_cnt_q;
    stall_d     = stall_q;
    blank_d     = (blank_q != '0) ? blank_q - ONE : '0;
    lock_d      = lock_q;
    ol_cnt_d    = ol_cnt_q;
    zc_seen_d   = zc_seen_q;
    pend_d      = pend_q;
    first_d     = first_q;
    commute     = 1'b0;
    zc_seen_now = 1'b0;
    lock_nxt    = '0;
    ol_nxt      = '0;
    new_period  = '0;

    status_d = '0;
    if (ena_i && (state_q == ST_ALIGN || state_q == ST_OPEN || state_q == ST_CLOSED)) begin
      status_d = step_pattern(step_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (ena_i) begin
          dir_d     = dir_i;
          step_d    = 3'd0;
          state_d   = ST_ALIGN;
          timer_d   = ALIGN_LAST;
          lock_d    = '0;
          ol_cnt_d  = '0;
          zc_seen_d = 1'b0;
        end
      end

      ST_ALIGN: begin
        if (timer_q == '0) begin
          state_d   = ST_OPEN;
          period_d  = START_P;
          timer_d   = START_P - ONE;
          commute   = 1'b1;
          zc_seen_d = 1'b0;
        end else begin
          timer_d = timer_q - ONE;
        end
      end

      ST_OPEN: begin
        if (zc_valid) zc_seen_d = 1'b1;
        if (timer_q == '0) begin
          // A ZC landing on the expiry cycle still counts for this commutation.
          zc_seen_now = zc_seen_q | zc_valid;
          lock_nxt    = zc_seen_now ? lock_q + ONE : '0;
          ol_nxt      = ol_cnt_q + ONE;
          lock_d      = lock_nxt;
          ol_cnt_d    = ol_nxt;
          zc_seen_d   = 1'b0;
          if (lock_nxt == LOCK_N) begin
            // period_q is kept: half of it seeds the first closed-loop delay.
            state_d   = ST_CLOSED;
            commute   = 1'b1;
            ivl_cnt_d = '0;
            stall_d   = '0;
            pend_d    = 1'b0;
            first_d   = 1'b1;
            timer_d   = '0;
          end else if (ol_nxt == OL_MAX) begin
            state_d = ST_FAULT;
            timer_d = '0;
          end else begin
            commute    = 1'b1;
            new_period = ({1'b0, period_q} >= RAMP_FLOOR) ? period_q - RAMP : MIN_P;
            period_d   = new_period;
            timer_d    = new_period - ONE;
          end
        end else begin
          timer_d = timer_q - ONE;
        end
      end

      ST_CLOSED: begin
        ivl_cnt_d = ivl_inc;
        if (pend_q) begin
          // timer holds the remaining delay; 0 and 1 both commute now.
          if (timer_q <= ONE) begin
            commute = 1'b1;
            pend_d  = 1'b0;
            stall_d = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q - ONE;
          end
        end else if (zc_valid) begin
          interval_d = ivl_inc;
          ivl_cnt_d  = '0;
          timer_d    = first_q ? (period_q >> 1) : (ivl_inc >> 1);
          pend_d     = 1'b1;
          first_d    = 1'b0;
          stall_d    = '0;
        end else if (stall_q == STALL_LAST) begin
          state_d = ST_FAULT;
        end else begin
          stall_d = stall_q + ONE;
        end
      end

      ST_FAULT: begin
      end

      default: state_d = ST_IDLE;
    endcase

    if (commute) begin
      step_d  = step_next(step_q, dir_q);
      blank_d = BLANK_N;
    end

    if (!ena_i) begin
      state_d   = ST_IDLE;
      step_d    = step_q;
      timer_d   = '0;
      period_d  = '0;
      ivl_cnt_d = '0;
      stall_d   = '0;
      blank_d   = '0;
      lock_d    = '0;
      ol_cnt_d  = '0;
      zc_seen_d = 1'b0;
      pend_d    = 1'b0;
      first_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      dir_q      <= 1'b0;
      status_q   <= '0;
      interval_q <= '0;
      timer_q    <= '0;
      period_q   <= '0;
      ivl_cnt_q  <= '0;
      stall_q    <= '0;
      blank_q    <= '0;
      lock_q     <= '0;
      ol_cnt_q   <= '0;
      zc_seen_q  <= 1'b0;
      pend_q     <= 1'b0;
      first_q    <= 1'b0;
      filt_q     <= '0;
      run_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      status_q   <= status_d;
      interval_q <= interval_d;
      timer_q    <= timer_d;
      period_q   <= period_d;
      ivl_cnt_q  <= ivl_cnt_d;
      stall_q    <= stall_d;
      blank_q    <= blank_d;
      lock_q     <= lock_d;
      ol_cnt_q   <= ol_cnt_d;
      zc_seen_q  <= zc_seen_d;
      pend_q     <= pend_d;
      first_q    <= first_d;
      filt_q     <= filt_d;
      run_q      <= run_d;
    end
  end

  assign status_o   = status_q;
  assign state_o    = state_q;
  assign locked_o   = (state_q == ST_CLOSED);
  assign fault_o    = (state_q == ST_FAULT);
  assign interval_o = interval_q;

endmodule
